// File: rtl/code_lock_ctrl_if.sv
// Button / status bundle for the code lock controller.
// The master side (front panel or test stimulus) drives the raw buttons;
// the slave side (code_lock_ctrl) drives the status outputs.
interface code_lock_ctrl_if;
    logic       p1;
    logic       p2;
    logic       unlocked;
    logic       lockout;
    logic       err;
    logic [2:0] entry_cnt;
    logic [1:0] fails;

    modport master (
        output p1,
        output p2,
        input  unlocked,
        input  lockout,
        input  err,
        input  entry_cnt,
        input  fails
    );

    modport slave (
        input  p1,
        input  p2,
        output unlocked,
        output lockout,
        output err,
        output entry_cnt,
        output fails
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// Two-button combination lock: debounces p1/p2, turns debounced rising
// edges into press events, checks each press against CODE, grants a timed
// unlock window on success and a timed lockout after MAX_TRIES failures.
// Optional feature macro: CODE_LOCK_TIMEOUT_EN -- abandons a partial entry
// after TIMEOUT_CYCLES cycles without a press (no err, no fails increment).
module code_lock_ctrl #(
    parameter int                  DEB_CYCLES     = 4,
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1100,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  UNLOCK_CYCLES  = 16,
    parameter int                  LOCKOUT_CYCLES = 32,
    parameter int                  TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    code_lock_ctrl_if.slave  bus
);

    // One shared down-counter covers every timed state, so size it for the longest.
    localparam int TMAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX    = (TMAX_UL > TIMEOUT_CYCLES) ? TMAX_UL : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] UNLOCK_T  = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LOCKOUT_T = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
`ifdef CODE_LOCK_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);
`endif
    localparam logic [7:0] CODE_EXT = 8'(CODE);
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [2:0] LEN_W    = 3'(CODE_LEN);
    localparam logic [1:0] TRIES_W  = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    entry_cnt_reg, entry_cnt_next;
    logic          bad_reg, bad_next;
    logic [1:0]    fails_reg, fails_next;
    logic          err_reg, err_next;
    logic [TW-1:0] timer_reg, timer_next;

    logic [1:0]    raw;
    logic [1:0]    press;
    logic [7:0]    code_bits;
    logic          press_any;
    logic          sym_ok;
    logic [2:0]    cnt_inc;
    logic [1:0]    fails_inc;

    assign raw       = {bus.p2, bus.p1};
    assign code_bits = CODE_EXT;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [7:0] cnt_reg;
            logic       level_reg;
            logic       press_reg;

            // Debounce one button and emit a one-cycle event on each debounced rise.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (raw[gi] != level_reg) begin
                        if (cnt_reg == DEB_LAST) begin
                            level_reg <= raw[gi];
                            cnt_reg   <= '0;
                            // Only a 0->1 transition of the debounced level is a press.
                            press_reg <= raw[gi];
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // Both buttons in one cycle is a single press with no valid symbol, so it never matches.
    assign press_any = |press;
    assign sym_ok    = ((press == 2'b01) && !code_bits[entry_cnt_reg]) ||
                       ((press == 2'b10) &&  code_bits[entry_cnt_reg]);
    assign cnt_inc   = entry_cnt_reg + 3'd1;
    assign fails_inc = fails_reg + 2'd1;

    // State and entry-tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            entry_cnt_reg <= '0;
            bad_reg       <= 1'b0;
            fails_reg     <= '0;
            err_reg       <= 1'b0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            entry_cnt_reg <= entry_cnt_next;
            bad_reg       <= bad_next;
            fails_reg     <= fails_next;
            err_reg       <= err_next;
            timer_reg     <= timer_next;
        end
    end

    // Next-state logic: sequence entry, judge completed entries, run the window timers.
    always_comb begin
        state_next     = state_reg;
        entry_cnt_next = entry_cnt_reg;
        bad_next       = bad_reg;
        fails_next     = fails_reg;
        err_next       = 1'b0;
        timer_next     = timer_reg;
        case (state_reg)
            S_IDLE, S_ENTRY: begin
                if (press_any) begin
                    if (cnt_inc == LEN_W) begin
                        entry_cnt_next = '0;
                        bad_next       = 1'b0;
                        if (bad_reg || !sym_ok) begin
                            err_next   = 1'b1;
                            fails_next = fails_inc;
                            if (fails_inc == TRIES_W) begin
                                state_next = S_LOCKOUT;
                                timer_next = LOCKOUT_T;
                            end else begin
                                state_next = S_IDLE;
                            end
                        end else begin
                            state_next = S_OPEN;
                            fails_next = '0;
                            timer_next = UNLOCK_T;
                        end
                    end else begin
                        // Keep going after a mismatch so the bad position is not revealed.
                        state_next     = S_ENTRY;
                        entry_cnt_next = cnt_inc;
                        bad_next       = bad_reg || !sym_ok;
`ifdef CODE_LOCK_TIMEOUT_EN
                        timer_next     = TIMEOUT_T;
`endif
                    end
                end
`ifdef CODE_LOCK_TIMEOUT_EN
                else if (state_reg == S_ENTRY) begin
                    if (timer_reg == TIMER_ONE) begin
                        state_next     = S_IDLE;
                        entry_cnt_next = '0;
                        bad_next       = 1'b0;
                    end else begin
                        timer_next = timer_reg - TIMER_ONE;
                    end
                end
`endif
            end
            S_OPEN: begin
                // Presses are dropped here, including one landing on the exit edge.
                if (timer_reg == TIMER_ONE) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end
            S_LOCKOUT: begin
                if (timer_reg == TIMER_ONE) begin
                    state_next = S_IDLE;
                    fails_next = '0;
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: window flags follow the state, err and counters come from registers.
    always_comb begin
        bus.unlocked  = (state_reg == S_OPEN);
        bus.lockout   = (state_reg == S_LOCKOUT);
        bus.err       = err_reg;
        bus.entry_cnt = entry_cnt_reg;
        bus.fails     = fails_reg;
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with default parameters (code p1,p1,p2,p2).
module tb_code_lock_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    code_lock_ctrl_if bus();

    code_lock_ctrl #(
        .DEB_CYCLES    (4),
        .CODE_LEN      (4),
        .CODE          (4'b1100),
        .MAX_TRIES     (3),
        .UNLOCK_CYCLES (16),
        .LOCKOUT_CYCLES(32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int unl_cnt  = 0;
    int lck_cnt  = 0;
    int err_cnt  = 0;

    // Count cycles of each status output, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.unlocked === 1'b1) unl_cnt++;
        if (bus.lockout === 1'b1) lck_cnt++;
        if (bus.err === 1'b1) err_cnt++;
    end

    task automatic clr_mon();
        unl_cnt = 0;
        lck_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic b1, input logic b2, input int hold, input int rel);
        @(posedge clk);
        #1;
        bus.p1 = b1;
        bus.p2 = b2;
        repeat (hold) @(posedge clk);
        #1;
        bus.p1 = 1'b0;
        bus.p2 = 1'b0;
        repeat (rel) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.p1 = 1'b0;
        bus.p2 = 1'b0;
        idle(3);
        n_checks++; if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked: got %b want 0", bus.unlocked); end
        n_checks++; if (bus.lockout !== 1'b0) begin n_fail++; $display("FAIL reset_lockout: got %b want 0", bus.lockout); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_entry_cnt: got %0d want 0", bus.entry_cnt); end
        n_checks++; if (bus.fails !== 2'd0) begin n_fail++; $display("FAIL reset_fails: got %0d want 0", bus.fails); end
        reset = 1'b0;
        idle(2);
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_correct_code();
        logic [2:0] exp_cnt [4];
        logic       syms    [4];
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd0};
        syms    = '{1'b0, 1'b0, 1'b1, 1'b1};
        clr_mon();
        for (int i = 0; i < 4; i++) begin
            press(!syms[i], syms[i], 8, 8);
            n_checks++; if (bus.entry_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL correct_entry_cnt%0d: got %0d want %0d", i, bus.entry_cnt, exp_cnt[i]); end
        end
        n_checks++; if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL correct_unlocked_now: got %b want 1", bus.unlocked); end
        idle(24);
        n_checks++; if (unl_cnt != 16) begin n_fail++; $display("FAIL correct_window_len: got %0d want 16", unl_cnt); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL correct_err_pulses: got %0d want 0", err_cnt); end
        n_checks++; if (bus.fails !== 2'd0) begin n_fail++; $display("FAIL correct_fails: got %0d want 0", bus.fails); end
        $display("test_correct_code: unlock window %0d cycles", unl_cnt);
    endtask

    task automatic test_glitch();
        clr_mon();
        @(posedge clk);
        #1 bus.p1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.p1 = 1'b0;
        idle(12);
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL glitch_entry_cnt: got %0d want 0", bus.entry_cnt); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL glitch_err: got %0d want 0", err_cnt); end
        $display("test_glitch: 3-cycle pulse, entry_cnt=%0d", bus.entry_cnt);
    endtask

    task automatic test_wrong_code();
        // Entry 1: p1,p2,p2,p2 (third and fourth positions correct, second wrong)
        clr_mon();
        press(1, 0, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8);
        idle(4);
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL wrong1_err_pulses: got %0d want 1", err_cnt); end
        n_checks++; if (bus.fails !== 2'd1) begin n_fail++; $display("FAIL wrong1_fails: got %0d want 1", bus.fails); end
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL wrong1_entry_cnt: got %0d want 0", bus.entry_cnt); end
        n_checks++; if (unl_cnt != 0) begin n_fail++; $display("FAIL wrong1_unlocked: got %0d want 0", unl_cnt); end
        $display("test_wrong_code: entry 1 fails=%0d", bus.fails);
        // Entry 2: p2,p2,p2,p2
        press(0, 1, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8);
        idle(4);
        n_checks++; if (bus.fails !== 2'd2) begin n_fail++; $display("FAIL wrong2_fails: got %0d want 2", bus.fails); end
        n_checks++; if (bus.lockout !== 1'b0) begin n_fail++; $display("FAIL wrong2_lockout: got %b want 0", bus.lockout); end
        $display("test_wrong_code: entry 2 fails=%0d", bus.fails);
        // Entry 3: p1,p1,p2,p1 -> lockout; then a press that must be ignored
        clr_mon();
        press(1, 0, 8, 8); press(1, 0, 8, 8); press(0, 1, 8, 8); press(1, 0, 8, 8);
        n_checks++; if (bus.lockout !== 1'b1) begin n_fail++; $display("FAIL wrong3_lockout: got %b want 1", bus.lockout); end
        n_checks++; if (bus.fails !== 2'd3) begin n_fail++; $display("FAIL wrong3_fails_in_lockout: got %0d want 3", bus.fails); end
        press(1, 0, 8, 8);
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL lockout_ignore_entry_cnt: got %0d want 0", bus.entry_cnt); end
        idle(20);
        n_checks++; if (lck_cnt != 32) begin n_fail++; $display("FAIL lockout_len: got %0d want 32", lck_cnt); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL wrong3_err_pulses: got %0d want 1", err_cnt); end
        n_checks++; if (bus.fails !== 2'd0) begin n_fail++; $display("FAIL after_lockout_fails: got %0d want 0", bus.fails); end
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL after_lockout_entry_cnt: got %0d want 0", bus.entry_cnt); end
        $display("test_wrong_code: lockout %0d cycles", lck_cnt);
    endtask

    task automatic test_open_ignore();
        clr_mon();
        press(1, 0, 8, 8); press(1, 0, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 4);
        // This press is debounced and reaches the FSM while the window is still open.
        press(1, 0, 8, 8);
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL open_ignore_entry_cnt: got %0d want 0", bus.entry_cnt); end
        idle(16);
        n_checks++; if (unl_cnt != 16) begin n_fail++; $display("FAIL open_ignore_window_len: got %0d want 16", unl_cnt); end
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL open_ignore_entry_after: got %0d want 0", bus.entry_cnt); end
        $display("test_open_ignore: unlock window %0d cycles", unl_cnt);
    endtask

    task automatic test_simultaneous();
        clr_mon();
        press(1, 1, 8, 8);
        n_checks++; if (bus.entry_cnt !== 3'd1) begin n_fail++; $display("FAIL simul_entry_cnt: got %0d want 1", bus.entry_cnt); end
        press(1, 0, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8);
        idle(4);
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL simul_err_pulses: got %0d want 1", err_cnt); end
        n_checks++; if (bus.fails !== 2'd1) begin n_fail++; $display("FAIL simul_fails: got %0d want 1", bus.fails); end
        n_checks++; if (unl_cnt != 0) begin n_fail++; $display("FAIL simul_unlocked: got %0d want 0", unl_cnt); end
        press(1, 0, 8, 8); press(1, 0, 8, 8); press(0, 1, 8, 8); press(0, 1, 8, 8);
        n_checks++; if (bus.fails !== 2'd0) begin n_fail++; $display("FAIL recover_fails: got %0d want 0", bus.fails); end
        idle(24);
        n_checks++; if (unl_cnt != 16) begin n_fail++; $display("FAIL recover_window_len: got %0d want 16", unl_cnt); end
        $display("test_simultaneous: err=%0d unlock=%0d", err_cnt, unl_cnt);
    endtask

    task automatic test_reset_mid_and_timeout();
        press(1, 0, 8, 8); press(1, 0, 8, 8);
        n_checks++; if (bus.entry_cnt !== 3'd2) begin n_fail++; $display("FAIL mid_entry_cnt: got %0d want 2", bus.entry_cnt); end
        // Hold p1 through reset: it must be re-debounced and count as a fresh press.
        bus.p1 = 1'b1;
        idle(8);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_reset_entry_cnt: got %0d want 0", bus.entry_cnt); end
        n_checks++; if ({bus.unlocked, bus.lockout, bus.err, bus.fails} !== 5'd0) begin n_fail++; $display("FAIL mid_reset_outputs: got %b want 00000", {bus.unlocked, bus.lockout, bus.err, bus.fails}); end
        idle(2);
        reset = 1'b0;
        idle(10);
        n_checks++; if (bus.entry_cnt !== 3'd1) begin n_fail++; $display("FAIL held_through_reset_entry_cnt: got %0d want 1", bus.entry_cnt); end
        bus.p1 = 1'b0;
        idle(8);
        press(1, 0, 8, 8);
        n_checks++; if (bus.entry_cnt !== 3'd2) begin n_fail++; $display("FAIL pre_timeout_entry_cnt: got %0d want 2", bus.entry_cnt); end
        clr_mon();
        idle(70);
`ifdef CODE_LOCK_TIMEOUT_EN
        n_checks++; if (bus.entry_cnt !== 3'd0) begin n_fail++; $display("FAIL timeout_entry_cnt: got %0d want 0", bus.entry_cnt); end
`else
        n_checks++; if (bus.entry_cnt !== 3'd2) begin n_fail++; $display("FAIL no_timeout_entry_cnt: got %0d want 2", bus.entry_cnt); end
`endif
        n_checks++; if (bus.fails !== 2'd0) begin n_fail++; $display("FAIL timeout_fails: got %0d want 0", bus.fails); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL timeout_err: got %0d want 0", err_cnt); end
        $display("test_reset_mid_and_timeout: entry_cnt after idle=%0d", bus.entry_cnt);
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_glitch();
        test_wrong_code();
        test_open_ignore();
        test_simultaneous();
        test_reset_mid_and_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Combination-lock controller for the two-pushbutton front end. It debounces raw buttons `p1`/`p2`, converts them into single press events, and compares each press against a parameterised code. It grants a timed unlock window on a correct entry and enforces a lockout after repeated failures. It replaces ad-hoc sequence detection with one block that sequences entry, attempts and timers.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive clk samples a raw level must hold before the debounced level follows (2..255).
- `CODE_LEN`, 4: presses per entry (1..7).
- `CODE`, 4'b1100: expected symbols, bit i = press i (i=0 first); 0 = `p1`, 1 = `p2`. The default is p1,p1,p2,p2.
- `MAX_TRIES`, 3: failed entries before lockout (1..3).
- `UNLOCK_CYCLES`, 16: length of the unlock window.
- `LOCKOUT_CYCLES`, 32: length of the lockout.
- `TIMEOUT_CYCLES`, 64: idle limit for a partial entry (used only with the macro).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `p1` in 1: raw button 1, asynchronous to nothing (already synchronous to clk).
- `p2` in 1: raw button 2.
- `unlocked` out 1: high for the whole OPEN window.
- `lockout` out 1: high for the whole LOCKOUT state.
- `err` out 1: one-cycle pulse when a completed entry is wrong.
- `entry_cnt` out 3: presses accepted in the current entry.
- `fails` out 2: failed entries since the last success or lockout.

## Operation
- **Reset values:** all outputs 0; state IDLE; debounced levels 0; all counters 0; `bad` flag 0.
- **Debouncer (one per button):**
  - The counter increments each cycle while raw != debounced, and clears when they are equal.
  - When the counter reaches DEB_CYCLES-1 with raw still differing, the debounced level takes raw and the counter clears.
- **Press event:** a registered pulse equal to debounced & ~debounced_prev, one cycle long per rising debounced edge. Releases generate nothing.
- **Symbol mapping:** a `p1` event alone is symbol 0 and a `p2` event alone is symbol 1. Both events in the same cycle are one press with an invalid symbol, which always mismatches.
- **States:**
  - **IDLE:** the first press moves to ENTRY and is processed as press 0.
  - **ENTRY:**
    - Each press compares against CODE[entry_cnt]. A mismatch sets `bad`, and entry continues regardless, so the failing position is not revealed. `entry_cnt` increments.
    - On the press that makes `entry_cnt` equal CODE_LEN:
      - If `bad` is 0: go to OPEN, clear `fails`.
      - Else: pulse `err`, increment `fails`. If the new `fails` equals MAX_TRIES, go to LOCKOUT; else go to IDLE.
    - `entry_cnt` and `bad` clear on leaving ENTRY.
  - **OPEN:** `unlocked`=1 for UNLOCK_CYCLES cycles, then IDLE. Presses are ignored (discarded, not queued).
  - **LOCKOUT:** `lockout`=1 for LOCKOUT_CYCLES cycles, then IDLE with `fails` cleared. Presses are ignored.
- **Counter widths:** the timer is sized to the largest of UNLOCK/LOCKOUT/TIMEOUT_CYCLES. It loads on state entry and counts down to 1; no wrap.
- **Reset mid-operation:** reset in any state returns immediately to the reset values. A button held through reset must be re-debounced from 0 and produces a press event.

## Timing
- **Raw to debounced:** a raw level stable from edge k updates the debounced level at edge k+DEB_CYCLES-1.
- **Press event** is high in the cycle after the debounced rise.
- **FSM** acts on the edge at which the press event is high. `unlocked`/`lockout`/`err` assert on that same edge, one cycle after the event cycle.
- **Window exit:** `unlocked` is high exactly UNLOCK_CYCLES cycles; `lockout` is high exactly LOCKOUT_CYCLES cycles. A press event on the exit edge is ignored.
- **Minimum press spacing:** 2·DEB_CYCLES+1 cycles (press plus release).

## Configuration
- **`CODE_LOCK_TIMEOUT_EN` defined:**
  - In ENTRY, an idle counter clears on every press.
  - After TIMEOUT_CYCLES cycles with no press, return to IDLE and clear `entry_cnt`/`bad`.
  - No `err` pulse and no `fails` increment on timeout.
- **`CODE_LOCK_TIMEOUT_EN` undefined:** no idle counter; a partial entry persists indefinitely.

## Test plan
- **Correct code:** press p1,p1,p2,p2 (each held 8, released 8 cycles) → `entry_cnt` 1,2,3,4→0; `unlocked`=1 for exactly 16 cycles; `fails`=0; `err` never.
- **Glitch rejection:** a 3-cycle p1 pulse → no press event; `entry_cnt` stays 0.
- **Wrong code:** p1,p2,p2,p2 → `err` pulses once after the 4th press, `fails`=1, IDLE; wrong entries 2 and 3 → `lockout`=1 for 32 cycles, then `fails`=0.
- **Ignored presses:** presses during OPEN and during LOCKOUT → `entry_cnt` stays 0; no extension of either window.
- **Simultaneous and fail-then-success:** p1 and p2 rising on the same edge as press 0, then p1,p2,p2 → `err`, `fails`=1; a following correct entry → `unlocked`, `fails`=0.
- **Reset and timeout:** reset asserted after 2 presses → all outputs 0 at once. With `CODE_LOCK_TIMEOUT_EN`: 2 presses then 64 idle cycles → `entry_cnt`=0, `fails` unchanged.
